// File: rtl/alu_register_file.sv
// Operand register file: R1-R4 and S1-S4 (16 bits each) with per-register functions and two zero-latency read ports.
// Build macro REGFILE_SATURATE_EN: increment/decrement saturate instead of wrapping.
module alu_register_file #(
  parameter int          DATA_WIDTH = 16,
  parameter logic [15:0] RESET_VAL  = 16'h0000
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] I,
  input  logic [2:0]            FunSel,
  input  logic [3:0]            RegSel,
  input  logic [3:0]            ScrSel,
  input  logic [2:0]            OutASel,
  input  logic [2:0]            OutBSel,
  output logic [DATA_WIDTH-1:0] OutA,
  output logic [DATA_WIDTH-1:0] OutB
);

  generate
    if (DATA_WIDTH != 16) begin : g_bad_width
      $error("alu_register_file: byte functions require DATA_WIDTH == 16");
    end
  endgenerate

  // Index 0-3 = R1-R4, 4-7 = S1-S4, matching the read-select encoding.
  logic [15:0] regs [0:7];
  logic [7:0]  en;

  assign en = {ScrSel[0], ScrSel[1], ScrSel[2], ScrSel[3],
               RegSel[0], RegSel[1], RegSel[2], RegSel[3]};

  function automatic logic [15:0] next_val(input logic [2:0]  fs,
                                           input logic [15:0] q,
                                           input logic [15:0] d);
    logic [15:0] r;
    r = q;
    case (fs)
`ifdef REGFILE_SATURATE_EN
      3'b000: r = (q == 16'h0000) ? q : q - 16'h0001;
      3'b001: r = (q == 16'hFFFF) ? q : q + 16'h0001;
`else
      3'b000: r = q - 16'h0001;
      3'b001: r = q + 16'h0001;
`endif
      3'b010: r = d;
      3'b011: r = 16'h0000;
      3'b100: r = {8'h00, d[7:0]};
      3'b101: r = {q[15:8], d[7:0]};
      3'b110: r = {d[7:0], q[7:0]};
      3'b111: r = {{8{d[7]}}, d[7:0]};
      default: r = q;
    endcase
    return r;
  endfunction

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < 8; k++) regs[k] <= RESET_VAL;
    end else begin
      for (int k = 0; k < 8; k++)
        if (en[k]) regs[k] <= next_val(FunSel, regs[k], I);
    end
  end

  // No bypass: a same-cycle write is only seen after the edge.
  assign OutA = regs[OutASel];
  assign OutB = regs[OutBSel];

endmodule

// File: tb/tb_alu_register_file.sv
// Scoreboarded directed bench for alu_register_file: stimulus queues expected read-port values, a negedge monitor compares.
module tb_alu_register_file;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] I;
  logic [2:0]  FunSel;
  logic [3:0]  RegSel, ScrSel;
  logic [2:0]  OutASel, OutBSel;
  logic [15:0] OutA, OutB;

  typedef struct {
    string       name;
    bit          portb;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  alu_register_file dut (
    .Clock(Clock), .Reset(Reset), .I(I), .FunSel(FunSel),
    .RegSel(RegSel), .ScrSel(ScrSel), .OutASel(OutASel), .OutBSel(OutBSel),
    .OutA(OutA), .OutB(OutB)
  );

  always #5 Clock = ~Clock;

  // Monitor: read ports are stable away from the rising edge.
  initial begin
    exp_t        e;
    logic [15:0] act;
    forever begin
      @(negedge Clock);
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        act = e.portb ? OutB : OutA;
        checks++;
        if (act !== e.val) begin
          fails++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.val);
        end
      end
    end
  end

  task automatic push(input string name, input bit portb, input logic [15:0] val);
    exp_t e;
    e.name = name; e.portb = portb; e.val = val;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic wr(input logic [3:0] rs, input logic [3:0] ss,
                    input logic [2:0] fs, input logic [15:0] d);
    RegSel = rs; ScrSel = ss; FunSel = fs; I = d;
    tick();
    RegSel = 4'b0000; ScrSel = 4'b0000;
  endtask

  task automatic chk(input string name, input logic [2:0] sel, input logic [15:0] val);
    RegSel = 4'b0000; ScrSel = 4'b0000;
    OutASel = sel;
    push(name, 1'b0, val);
    tick();
  endtask

  task automatic chk2(input string name, input logic [2:0] sela, input logic [2:0] selb,
                      input logic [15:0] va, input logic [15:0] vb);
    RegSel = 4'b0000; ScrSel = 4'b0000;
    OutASel = sela; OutBSel = selb;
    push({name, "_A"}, 1'b0, va);
    push({name, "_B"}, 1'b1, vb);
    tick();
  endtask

  initial begin
    int budget;
    Reset = 1'b1; I = 16'h0; FunSel = 3'b000; RegSel = 4'b0; ScrSel = 4'b0;
    OutASel = 3'd0; OutBSel = 3'd0;
    tick();
    for (int k = 0; k < 8; k++) chk($sformatf("reset_r%0d", k), 3'(k), 16'h0000);
    Reset = 1'b0;
    tick();

    // Load all eight, then async reset between edges.
    wr(4'b1111, 4'b1111, 3'b010, 16'hA5A5);
    chk2("loaded_r1_s4", 3'd0, 3'd7, 16'hA5A5, 16'hA5A5);
    Reset = 1'b1;
    chk2("async_rst_r1_s4", 3'd0, 3'd7, 16'h0000, 16'h0000);
    wr(4'b1111, 4'b1111, 3'b010, 16'hFFFF);
    chk2("rst_held_r2_s1", 3'd1, 3'd4, 16'h0000, 16'h0000);
    chk2("rst_held_r3_s3", 3'd2, 3'd6, 16'h0000, 16'h0000);
    Reset = 1'b0;
    tick();

    // Load and readback.
    wr(4'b1000, 4'b0000, 3'b010, 16'h1234);
    chk2("load_r1_r2", 3'd0, 3'd1, 16'h1234, 16'h0000);

    // Byte functions on S2.
    wr(4'b0000, 4'b0100, 3'b010, 16'hBEEF);
    wr(4'b0000, 4'b0100, 3'b101, 16'h0080);
    chk("byte_lo", 3'd5, 16'hBE80);
    wr(4'b0000, 4'b0100, 3'b010, 16'hBEEF);
    wr(4'b0000, 4'b0100, 3'b110, 16'h0080);
    chk("byte_hi", 3'd5, 16'h80EF);
    wr(4'b0000, 4'b0100, 3'b010, 16'hBEEF);
    wr(4'b0000, 4'b0100, 3'b111, 16'h0080);
    chk("byte_sext", 3'd5, 16'hFF80);
    wr(4'b0000, 4'b0100, 3'b010, 16'hBEEF);
    wr(4'b0000, 4'b0100, 3'b100, 16'h0080);
    chk("byte_zext", 3'd5, 16'h0080);
    wr(4'b0000, 4'b0100, 3'b111, 16'h0041);
    chk("byte_sext_pos", 3'd5, 16'h0041);

    // Inc/dec boundaries.
    wr(4'b0010, 4'b0000, 3'b010, 16'hFFFF);
    wr(4'b0010, 4'b0000, 3'b001, 16'h0000);
    wr(4'b0001, 4'b0000, 3'b011, 16'h0000);
    wr(4'b0001, 4'b0000, 3'b000, 16'h0000);
`ifdef REGFILE_SATURATE_EN
    chk2("inc_dec_bound", 3'd2, 3'd3, 16'hFFFF, 16'h0000);
`else
    chk2("inc_dec_bound", 3'd2, 3'd3, 16'h0000, 16'hFFFF);
`endif
    wr(4'b0001, 4'b0000, 3'b010, 16'h0100);
    wr(4'b0001, 4'b0000, 3'b000, 16'h0000);
    chk("dec_mid", 3'd3, 16'h00FF);

    // Multi-select increment with same-cycle read of R1.
    wr(4'b1000, 4'b0000, 3'b010, 16'd5);
    wr(4'b0100, 4'b0000, 3'b010, 16'd9);
    wr(4'b0000, 4'b1111, 3'b010, 16'h3C3C);
    OutASel = 3'd0; RegSel = 4'b1100; ScrSel = 4'b0000; FunSel = 3'b001;
    push("pre_edge_r1", 1'b0, 16'd5);
    tick();
    RegSel = 4'b0000;
    chk2("multi_inc_r1_r2", 3'd0, 3'd1, 16'd6, 16'd10);
    chk2("multi_s1_s2", 3'd4, 3'd5, 16'h3C3C, 16'h3C3C);
    chk2("multi_s3_s4", 3'd6, 3'd7, 16'h3C3C, 16'h3C3C);

    // Idle enables with X function: no change.
    RegSel = 4'b0000; ScrSel = 4'b0000; FunSel = 3'bxxx;
    tick(); tick();
    FunSel = 3'b000;
    chk2("idle_x_r1_r2", 3'd0, 3'd1, 16'd6, 16'd10);

    // Dual read of same register, then clear.
    wr(4'b0000, 4'b0001, 3'b010, 16'h7777);
    chk2("dual_s4", 3'd7, 3'd7, 16'h7777, 16'h7777);
    wr(4'b0000, 4'b0001, 3'b011, 16'h5555);
    chk2("dual_s4_clr", 3'd7, 3'd7, 16'h0000, 16'h0000);
    chk("clr_s3_kept", 3'd6, 16'h3C3C);

    budget = 20;
    while (sb.size() > 0 && budget > 0) begin
      @(posedge Clock);
      budget--;
    end
    if (sb.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/alu_register_file.md
Name: alu_register_file

Overview:
- Operand-source stage directly upstream of the ALU.
- Holds four general-purpose registers R1–R4 and four scratch registers S1–S4, each 16 bits.
- Two independent read ports, OutA and OutB, drive the ALU A and B inputs.
- Each selected register performs a per-cycle function (load, clear, increment, decrement, byte writes) on input I, which the datapath drives from ALUOut or the memory/instruction path.

Parameters:
- DATA_WIDTH, 16, register width; the byte functions are defined for 16 only, so other values are illegal.
- RESET_VAL, 16'h0000, value loaded into all eight registers on reset.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high; clears all registers to RESET_VAL.
- I  input  16  write data (ALUOut or bus).
- FunSel  input  3  register function applied to every enabled register.
- RegSel  input  4  active-high enables: bit3=R1, bit2=R2, bit1=R3, bit0=R4.
- ScrSel  input  4  active-high enables: bit3=S1, bit2=S2, bit1=S3, bit0=S4.
- OutASel  input  3  read port A select: 000–011 = R1–R4, 100–111 = S1–S4.
- OutBSel  input  3  read port B select, same encoding as OutASel.
- OutA  output  16  read port A data (to ALU A).
- OutB  output  16  read port B data (to ALU B).

Behaviour:
- Reset asserted (async):
  - All R and S registers become RESET_VAL immediately, regardless of Clock.
  - OutA/OutB then reflect RESET_VAL through the mux.
  - Writes are ignored while Reset is high.
  - Reset in the middle of a write sequence discards that sequence; there is no partial state.
- Writes occur on the rising Clock edge, only to registers whose RegSel/ScrSel bit is 1. Unselected registers hold.
- FunSel encoding, where Q = current register value:
  - 000: Q-1, wraps 0x0000 -> 0xFFFF.
  - 001: Q+1, wraps 0xFFFF -> 0x0000.
  - 010: load I.
  - 011: clear to 0x0000.
  - 100: {8'h00, I[7:0]}.
  - 101: {Q[15:8], I[7:0]} (low byte only).
  - 110: {I[7:0], Q[7:0]} (I low byte into high byte).
  - 111: {{8{I[7]}}, I[7:0]} (sign-extend).
- Multiple enable bits set: each selected register applies FunSel to its own Q independently. Example: inc on R1 and R2 increments each separately.
- All-zero enables with any FunSel: no state change.
- Read ports:
  - Purely combinational mux of current register state; zero latency.
  - A write at edge n is visible on OutA/OutB after edge n. There is no write-through bypass.
  - OutA and OutB may select the same register simultaneously.
- Read/write to the same register in one cycle: the read returns the old value until the edge. This supports the ALU loop R1 <- R1 op R2 in a single cycle.
- Every FunSel code is defined; X on FunSel with enables low has no effect.

Optional Feature:
- Macro: REGFILE_SATURATE_EN.
- Defined:
  - FunSel 001 saturates at 0xFFFF: increment of 0xFFFF holds 0xFFFF.
  - FunSel 000 saturates at 0x0000: decrement of 0x0000 holds 0x0000.
- Undefined: increment and decrement wrap modulo 2^16 as above.
- All other functions are identical in both builds.

Test Plan:
- Reset:
  - Load all eight registers with 0xA5A5.
  - Assert Reset between clock edges -> OutA/OutB read 0x0000 immediately, with no Clock edge.
  - With Reset held high, FunSel=010 and all enables set -> registers stay 0x0000.
- Load and readback:
  - I=0x1234, RegSel=1000, FunSel=010, one edge.
  - OutASel=000 -> OutA=0x1234.
  - OutBSel=001 -> OutB=0x0000 (R2 untouched).
- Byte functions on S2 = 0xBEEF, I=0x0080:
  - FunSel=101 -> 0xBE80.
  - FunSel=110 -> 0x80EF.
  - FunSel=111 -> 0xFF80.
  - FunSel=100 -> 0x0080.
- Inc/dec boundaries:
  - R3=0xFFFF, FunSel=001 -> 0x0000 (0xFFFF with REGFILE_SATURATE_EN).
  - R4=0x0000, FunSel=000 -> 0xFFFF (0x0000 with REGFILE_SATURATE_EN).
- Multi-select and same-cycle read:
  - R1=5, R2=9, RegSel=1100, FunSel=001, OutASel=000.
  - Before the edge, OutA=5. After the edge, R1=6 and R2=10; S1–S4 unchanged.
- Dual read of the same register:
  - S4=0x7777, OutASel=OutBSel=111 -> OutA=OutB=0x7777.
  - Clear S4 -> both read 0x0000 after the edge.
